bist_scheduler: RTL and testbench

BIST_SCHEDULER -- requirements
Module: bist_scheduler

---
 rtl/bist_pkg.sv | 26 ++
 rtl/bist_next_unit.sv | 28 ++
 rtl/bist_scheduler.sv | 164 ++++++++++++++++
 tb/tb_bist_scheduler.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the BIST scheduler: FSM state encoding and a
// width helper used to size counters and unit indices from parameters.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    // Bits needed to index n distinct values; never less than 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 1) ? n - 1 : 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/bist_next_unit.sv
// Combinational search for the lowest set mask bit above (or, with i_incl,
// at or above) a given index.
module bist_next_unit
    import bist_pkg::*;
#(
    parameter int   N_UNITS = 4,
    localparam int  UW      = clog2(N_UNITS)
) (
    input  logic [N_UNITS-1:0] i_mask,
    input  logic [UW-1:0]      i_idx,
    input  logic               i_incl,
    output logic [UW-1:0]      o_idx,
    output logic               o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            if (!o_found && i_mask[i] &&
                ((i > 32'(i_idx)) || (i_incl && (i == 32'(i_idx))))) begin
                o_idx   = UW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bist_scheduler.sv
// Sequences one shared BIST engine across the units selected in a mask,
// collecting per-unit pass/fail/timeout results.
module bist_scheduler
    import bist_pkg::*;
#(
    parameter int   N_UNITS    = 4,
    parameter int   TIMEOUT    = 1023,
    parameter int   GAP_CYCLES = 2,
    localparam int  UW         = clog2(N_UNITS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [N_UNITS-1:0] unit_mask,
    input  logic               bist_done,
    input  logic               bist_error,
    output logic               run_sel,
    output logic [UW-1:0]      unit_sel,
    output logic               busy,
    output logic               done,
    output logic [N_UNITS-1:0] pass_vec,
    output logic [N_UNITS-1:0] fail_vec,
    output logic [N_UNITS-1:0] tmo_vec,
    output logic               aborted
);

    localparam int CW = clog2(TIMEOUT + 1);
    localparam int GW = clog2(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t             r_state,   w_state_nx;
    logic [UW-1:0]      r_ptr,     w_ptr_nx;
    logic [N_UNITS-1:0] r_mask,    w_mask_nx;
    logic [CW-1:0]      r_cnt,     w_cnt_nx;
    logic [GW-1:0]      r_gap,     w_gap_nx;
    logic [N_UNITS-1:0] r_pass,    w_pass_nx;
    logic [N_UNITS-1:0] r_fail,    w_fail_nx;
    logic [N_UNITS-1:0] r_tmo,     w_tmo_nx;
    logic               r_aborted, w_aborted_nx;

    logic [UW-1:0]      w_first_idx, w_next_idx;
    logic               w_first_found, w_next_found;

    bist_next_unit #(.N_UNITS(N_UNITS)) u_first (
        .i_mask  (unit_mask),
        .i_idx   ('0),
        .i_incl  (1'b1),
        .o_idx   (w_first_idx),
        .o_found (w_first_found)
    );

    bist_next_unit #(.N_UNITS(N_UNITS)) u_next (
        .i_mask  (r_mask),
        .i_idx   (r_ptr),
        .i_incl  (1'b0),
        .o_idx   (w_next_idx),
        .o_found (w_next_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_mask    <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_pass    <= '0;
            r_fail    <= '0;
            r_tmo     <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_ptr     <= w_ptr_nx;
            r_mask    <= w_mask_nx;
            r_cnt     <= w_cnt_nx;
            r_gap     <= w_gap_nx;
            r_pass    <= w_pass_nx;
            r_fail    <= w_fail_nx;
            r_tmo     <= w_tmo_nx;
            r_aborted <= w_aborted_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_ptr_nx     = r_ptr;
        w_mask_nx    = r_mask;
        w_cnt_nx     = r_cnt;
        w_gap_nx     = r_gap;
        w_pass_nx    = r_pass;
        w_fail_nx    = r_fail;
        w_tmo_nx     = r_tmo;
        w_aborted_nx = r_aborted;

        // Abort outranks every other event, including a same-cycle bist_done.
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nx   = ST_IDLE;
            w_aborted_nx = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_mask_nx    = unit_mask;
                        w_pass_nx    = '0;
                        w_fail_nx    = '0;
                        w_tmo_nx     = '0;
                        w_aborted_nx = 1'b0;
                        if (w_first_found) begin
                            w_ptr_nx   = w_first_idx;
                            w_state_nx = ST_ARM;
                        end else begin
                            w_state_nx = ST_FINISH;
                        end
                    end
                end
                ST_ARM: begin
                    w_cnt_nx   = '0;
                    w_state_nx = ST_RUN;
                end
                ST_RUN: begin
                    if (bist_done) begin
                        if (bist_error) w_fail_nx[r_ptr] = 1'b1;
                        else            w_pass_nx[r_ptr] = 1'b1;
                        w_gap_nx   = '0;
                        w_state_nx = ST_GAP;
                    end else if (r_cnt == CNT_LAST) begin
                        w_fail_nx[r_ptr] = 1'b1;
                        w_tmo_nx[r_ptr]  = 1'b1;
                        w_gap_nx         = '0;
                        w_state_nx       = ST_GAP;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_gap == GAP_LAST) begin
                        if (w_next_found) begin
                            w_ptr_nx   = w_next_idx;
                            w_state_nx = ST_ARM;
                        end else begin
                            w_state_nx = ST_FINISH;
                        end
                    end else begin
                        w_gap_nx = r_gap + 1'b1;
                    end
                end
                ST_FINISH: w_state_nx = ST_IDLE;
                default:   w_state_nx = ST_IDLE;
            endcase
        end
    end

    assign run_sel  = (r_state == ST_RUN);
    assign unit_sel = r_ptr;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_FINISH) && !abort;
    assign pass_vec = r_pass;
    assign fail_vec = r_fail;
    assign tmo_vec  = r_tmo;
    assign aborted  = r_aborted;

endmodule

// File: tb/tb_bist_scheduler.sv
// Directed bench for bist_scheduler: table-driven campaigns against a simple
// engine model, plus hand sequences for abort, reset and mask-zero timing.
module tb_bist_scheduler;

    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int GAP = 2;

    logic         clk = 1'b0;
    logic         rst_n, start, abort, bist_done, bist_error;
    logic [N-1:0] unit_mask, pass_vec, fail_vec, tmo_vec;
    logic [1:0]   unit_sel;
    logic         run_sel, busy, done, aborted;

    int checks = 0;
    int errors = 0;

    // Engine model: finishes in its e_lat-th RUN cycle (e_lat = 0: never).
    int   e_lat;
    logic e_err;
    int   ecnt;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        ecnt <= 0;
        else if (!run_sel) ecnt <= 0;
        else               ecnt <= ecnt + 1;
    end

    assign bist_done  = run_sel && (e_lat > 0) && (ecnt == e_lat - 1);
    assign bist_error = e_err;

    bist_scheduler #(.N_UNITS(N), .TIMEOUT(TMO), .GAP_CYCLES(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .unit_mask  (unit_mask),
        .bist_done  (bist_done),
        .bist_error (bist_error),
        .run_sel    (run_sel),
        .unit_sel   (unit_sel),
        .busy       (busy),
        .done       (done),
        .pass_vec   (pass_vec),
        .fail_vec   (fail_vec),
        .tmo_vec    (tmo_vec),
        .aborted    (aborted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] mask;
        int           lat;
        logic         err;
        int           restart;
        logic [N-1:0] pass;
        logic [N-1:0] fail;
        logic [N-1:0] tmo;
        int           runc;
        logic [15:0]  ord;
        int           donek;
    } vec_t;

    vec_t tbl [7];

    task automatic run_campaign(input vec_t v, output int runc, output logic [15:0] ord,
                                output int dcnt, output int donek, output bit finished);
        bit prev_run;
        runc = 0; ord = '0; dcnt = 0; donek = -1; finished = 1'b0; prev_run = 1'b0;
        e_lat = v.lat; e_err = v.err;
        unit_mask = v.mask; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (run_sel) runc++;
            if (run_sel && !prev_run) ord = {ord[11:0], 2'b00, unit_sel};
            prev_run = run_sel;
            if (done) begin
                dcnt++;
                if (donek < 0) donek = k;
            end
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            start     = (k == v.restart);
            unit_mask = (k == v.restart) ? 4'hF : v.mask;
            step();
        end
        start = 1'b0;
    endtask

    initial begin
        int runc, dcnt, donek;
        logic [15:0] ord;
        bit fin, found;

        //        mask     lat err rst  pass     fail     tmo      runc ord       donek
        tbl[0] = '{4'b1011, 5, 0, -1, 4'b1011, 4'b0000, 4'b0000, 15, 16'h0013, 24};
        tbl[1] = '{4'b0100, 5, 1, -1, 4'b0000, 4'b0100, 4'b0000,  5, 16'h0002,  8};
        tbl[2] = '{4'b0001, 0, 0, -1, 4'b0000, 4'b0001, 4'b0001,  8, 16'h0000, 11};
        tbl[3] = '{4'b1000, 8, 0, -1, 4'b1000, 4'b0000, 4'b0000,  8, 16'h0003, 11};
        tbl[4] = '{4'b0110, 3, 1, -1, 4'b0000, 4'b0110, 4'b0000,  6, 16'h0012, 12};
        tbl[5] = '{4'b0011, 5, 1,  3, 4'b0000, 4'b0011, 4'b0000, 10, 16'h0001, 16};
        tbl[6] = '{4'b0000, 5, 0, -1, 4'b0000, 4'b0000, 4'b0000,  0, 16'h0000,  0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; unit_mask = '0; e_lat = 0; e_err = 1'b0;
        #2;
        chk("rst_outputs", {28'd0, run_sel, busy, done, aborted}, 32'h0);
        chk("rst_unit_sel", {30'd0, unit_sel}, 32'h0);
        chk("rst_vecs", {20'd0, pass_vec, fail_vec, tmo_vec}, 32'h0);
        #10 rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_campaign(tbl[i], runc, ord, dcnt, donek, fin);
            chk($sformatf("v%0d_finished", i), {31'd0, fin}, 32'h1);
            chk($sformatf("v%0d_pass", i), {28'd0, pass_vec}, {28'd0, tbl[i].pass});
            chk($sformatf("v%0d_fail", i), {28'd0, fail_vec}, {28'd0, tbl[i].fail});
            chk($sformatf("v%0d_tmo", i), {28'd0, tmo_vec}, {28'd0, tbl[i].tmo});
            chk($sformatf("v%0d_run_cycles", i), 32'(runc), 32'(tbl[i].runc));
            chk($sformatf("v%0d_order", i), {16'd0, ord}, {16'd0, tbl[i].ord});
            chk($sformatf("v%0d_done_count", i), 32'(dcnt), 32'd1);
            chk($sformatf("v%0d_done_cycle", i), 32'(donek), 32'(tbl[i].donek));
            chk($sformatf("v%0d_aborted", i), {31'd0, aborted}, 32'h0);
            step();
        end

        // Abort in the very cycle unit 2 reports done: its result must be dropped.
        e_lat = 5; e_err = 1'b0; unit_mask = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        dcnt  = 0;
        for (int k = 0; k < 100; k++) begin
            if (done) dcnt++;
            if (run_sel && unit_sel == 2'd2) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("abort_reach_unit2", {31'd0, found}, 32'h1);
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_run_sel", {31'd0, run_sel}, 32'h0);
        chk("abort_busy", {31'd0, busy}, 32'h0);
        chk("abort_aborted", {31'd0, aborted}, 32'h1);
        chk("abort_pass", {28'd0, pass_vec}, 32'h3);
        chk("abort_fail", {28'd0, fail_vec | tmo_vec}, 32'h0);
        for (int k = 0; k < 6; k++) begin
            if (done) dcnt++;
            step();
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_aborted", {31'd0, aborted}, 32'h1);
        chk("idle_abort_busy", {31'd0, busy}, 32'h0);
        chk("idle_abort_pass", {28'd0, pass_vec}, 32'h3);

        // Mask zero: FINISH right after the start edge, then IDLE; aborted cleared.
        unit_mask = 4'b0000; start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_done_first", {29'd0, done, busy, run_sel}, 32'h6);
        chk("zero_aborted_clr", {31'd0, aborted}, 32'h0);
        chk("zero_vecs", {20'd0, pass_vec, fail_vec, tmo_vec}, 32'h0);
        step();
        chk("zero_done_end", {30'd0, done, busy}, 32'h0);

        // Reset pulsed mid-RUN of unit 1, away from any clock edge.
        e_lat = 5; e_err = 1'b0; unit_mask = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (run_sel && unit_sel == 2'd1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("rst_reach_unit1", {31'd0, found}, 32'h1);
        chk("rst_pre_pass", {28'd0, pass_vec}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", {28'd0, run_sel, busy, done, aborted}, 32'h0);
        chk("async_rst_unit_sel", {30'd0, unit_sel}, 32'h0);
        chk("async_rst_vecs", {20'd0, pass_vec, fail_vec, tmo_vec}, 32'h0);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_idle", {30'd0, busy, run_sel}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
